// File: rtl/if_trace_tracker_mo_pkg.sv
// Shared types and record layout helpers for the IF-stage fetch tracker.
// Record layout, MSB first: addr, instr, t_req, t_gnt, t_end, killed.
package if_trace_tracker_mo_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } if_req_state_e;

    // In-flight entry: {addr, t_req, t_gnt}
    function automatic int inflight_width(input int aw, input int tw);
        return aw + 2 * tw;
    endfunction

    function automatic int rec_width(input int aw, input int dw, input int tw);
        return aw + dw + 3 * tw + 1;
    endfunction

endpackage

// File: rtl/if_trace_tracker_mo_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module trace_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_trace_tracker_mo.sv
// IF-stage fetch tracker: pairs req/gnt with rvalid and emits one timestamped
// trace record per completed fetch through a buffered valid/ready port.
module if_trace_tracker_mo
    import if_trace_tracker_mo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIME_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int OUT_DEPTH       = 4,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_req,
    input  logic [ADDR_WIDTH-1:0]     instr_addr,
    input  logic                      instr_grant,
    input  logic                      instr_rvalid,
    input  logic [DATA_WIDTH-1:0]     instr_rdata,
    input  logic                      flush_i,
    input  logic [TIME_WIDTH-1:0]     counter_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [ADDR_WIDTH-1:0]     trace_addr_o,
    output logic [DATA_WIDTH-1:0]     trace_instr_o,
    output logic [TIME_WIDTH-1:0]     trace_t_req_o,
    output logic [TIME_WIDTH-1:0]     trace_t_gnt_o,
    output logic [TIME_WIDTH-1:0]     trace_t_end_o,
    output logic                      trace_killed_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                      proto_err_o
);

    localparam int IF_W   = inflight_width(ADDR_WIDTH, TIME_WIDTH);
    localparam int REC_W  = rec_width(ADDR_WIDTH, DATA_WIDTH, TIME_WIDTH);
    localparam int KILL_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OCNT_W = $clog2(OUT_DEPTH + 1);

    if_req_state_e            state;
    logic [TIME_WIDTH-1:0]    t_req_q;
    logic [KILL_W-1:0]        kill_cnt;

    logic                     grant_evt;
    logic [TIME_WIDTH-1:0]    grant_t_req;
    logic                     if_push;
    logic                     if_pop;
    logic                     if_full;
    logic                     if_empty;
    logic [KILL_W-1:0]        if_count;
    logic [IF_W-1:0]          if_push_data;
    logic [IF_W-1:0]          if_pop_data;
    logic                     if_overflow;
    logic                     rv_orphan;

    logic [REC_W-1:0]         rec_in;
    logic [REC_W-1:0]         rec_head;
    logic [REC_W-1:0]         rec_out;
    logic                     of_pop;
    logic                     of_full;
    logic                     of_empty;
    logic [OCNT_W-1:0]        of_count;
    logic                     rec_drop;
    logic                     unused_of_count;

    // A grant only counts while a request is live or one is already pending.
    assign grant_evt    = instr_grant && ((state == WAIT_GNT) || instr_req);
    assign grant_t_req  = (state == IDLE) ? counter_i : t_req_q;
    assign if_push_data = {instr_addr, grant_t_req, counter_i};

    assign if_pop       = instr_rvalid && !if_empty;
    assign if_push      = grant_evt && (!if_full || if_pop);
    assign if_overflow  = grant_evt && if_full && !if_pop;
    assign rv_orphan    = instr_rvalid && if_empty;

    assign rec_in = {if_pop_data[IF_W-1 -: ADDR_WIDTH], instr_rdata,
                     if_pop_data[2*TIME_WIDTH-1 -: TIME_WIDTH],
                     if_pop_data[TIME_WIDTH-1:0], counter_i, (kill_cnt != '0)};

    assign trace_valid_o = !of_empty;
    assign of_pop        = trace_valid_o && trace_ready_i;
    assign rec_drop      = if_pop && of_full && !of_pop;
    assign unused_of_count = ^of_count;

    trace_sync_fifo #(.WIDTH(IF_W), .DEPTH(MAX_OUTSTANDING)) u_inflight_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (if_push),
        .push_data (if_push_data),
        .pop       (if_pop),
        .pop_data  (if_pop_data),
        .full      (if_full),
        .empty     (if_empty),
        .count     (if_count)
    );

    trace_sync_fifo #(.WIDTH(REC_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (if_pop),
        .push_data (rec_in),
        .pop       (of_pop),
        .pop_data  (rec_head),
        .full      (of_full),
        .empty     (of_empty),
        .count     (of_count)
    );

    // Record fields read as zero whenever nothing is presented.
    assign rec_out        = trace_valid_o ? rec_head : '0;
    assign trace_killed_o = rec_out[0];
    assign trace_t_end_o  = rec_out[TIME_WIDTH -: TIME_WIDTH];
    assign trace_t_gnt_o  = rec_out[2*TIME_WIDTH -: TIME_WIDTH];
    assign trace_t_req_o  = rec_out[3*TIME_WIDTH -: TIME_WIDTH];
    assign trace_instr_o  = rec_out[3*TIME_WIDTH+DATA_WIDTH -: DATA_WIDTH];
    assign trace_addr_o   = rec_out[REC_W-1 -: ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t_req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_req && !instr_grant) begin
                        state   <= WAIT_GNT;
                        t_req_q <= counter_i;
                    end
                end
                WAIT_GNT: begin
                    if (instr_grant || !instr_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush marks everything still in flight after this cycle's pop; a same-cycle grant survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_cnt <= '0;
        end else if (flush_i) begin
            kill_cnt <= if_count - KILL_W'(if_pop);
        end else if (if_pop && (kill_cnt != '0)) begin
            kill_cnt <= kill_cnt - KILL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_o  <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (rec_drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 1'b1;
            if (if_overflow || rv_orphan) proto_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_trace_tracker_mo.sv
// Directed self-checking bench for if_trace_tracker_mo. In-flight depth is 3 so a
// flush can see two fetches in flight together with a same-cycle grant.
module tb_if_trace_tracker_mo;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_grant;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        flush_i;
    logic [31:0] counter_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_addr_o;
    logic [31:0] trace_instr_o;
    logic [31:0] trace_t_req_o;
    logic [31:0] trace_t_gnt_o;
    logic [31:0] trace_t_end_o;
    logic        trace_killed_o;
    logic [15:0] drop_cnt_o;
    logic        proto_err_o;

    int total = 0;
    int bad   = 0;

    if_trace_tracker_mo #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIME_WIDTH(32),
        .MAX_OUTSTANDING(3), .OUT_DEPTH(4), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req      (instr_req),
        .instr_addr     (instr_addr),
        .instr_grant    (instr_grant),
        .instr_rvalid   (instr_rvalid),
        .instr_rdata    (instr_rdata),
        .flush_i        (flush_i),
        .counter_i      (counter_i),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_addr_o   (trace_addr_o),
        .trace_instr_o  (trace_instr_o),
        .trace_t_req_o  (trace_t_req_o),
        .trace_t_gnt_o  (trace_t_gnt_o),
        .trace_t_end_o  (trace_t_end_o),
        .trace_killed_o (trace_killed_o),
        .drop_cnt_o     (drop_cnt_o),
        .proto_err_o    (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of bus inputs, clock it in, then advance trace time.
    task automatic apply_stimulus(input logic req, input logic [31:0] addr, input logic gnt,
                                  input logic rv, input logic [31:0] rdata,
                                  input logic flush, input logic ready);
        instr_req     = req;
        instr_addr    = addr;
        instr_grant   = gnt;
        instr_rvalid  = rv;
        instr_rdata   = rdata;
        flush_i       = flush;
        trace_ready_i = ready;
        @(posedge clk);
        #1;
        counter_i = counter_i + 32'd1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_record(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] treq, input logic [31:0] tgnt,
                                input logic [31:0] tend, input logic killed);
        check_output({tag, "_valid"},  64'(trace_valid_o),  64'd1);
        check_output({tag, "_addr"},   64'(trace_addr_o),   64'(addr));
        check_output({tag, "_instr"},  64'(trace_instr_o),  64'(instr));
        check_output({tag, "_t_req"},  64'(trace_t_req_o),  64'(treq));
        check_output({tag, "_t_gnt"},  64'(trace_t_gnt_o),  64'(tgnt));
        check_output({tag, "_t_end"},  64'(trace_t_end_o),  64'(tend));
        check_output({tag, "_killed"}, 64'(trace_killed_o), 64'(killed));
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = '0; instr_grant = 1'b0; instr_rvalid = 1'b0;
        instr_rdata = '0; flush_i = 1'b0; trace_ready_i = 1'b0; counter_i = '0;
        $display("[TB] reset");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("rst_valid", 64'(trace_valid_o), 64'd0);
        check_output("rst_drop",  64'(drop_cnt_o),    64'd0);
        check_output("rst_err",   64'(proto_err_o),   64'd0);
        check_output("rst_addr",  64'(trace_addr_o),  64'd0);
        rst = 1'b0;

        $display("[TB] single fetch");
        counter_i = 32'd10;
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'h100, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("single_pre_valid", 64'(trace_valid_o), 64'd0);
        apply_stimulus(0, 0, 0, 1, 32'h13, 0, 0);
        check_record("single", 32'h100, 32'h13, 32'd10, 32'd12, 32'd15, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("single_popped", 64'(trace_valid_o), 64'd0);

        $display("[TB] pipelined");
        counter_i = 32'd40;
        apply_stimulus(1, 32'h200, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h204, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'hA, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'hB, 0, 0);
        check_record("pipe0", 32'h200, 32'hA, 32'd40, 32'd40, 32'd43, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_record("pipe1", 32'h204, 32'hB, 32'd41, 32'd41, 32'd44, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("pipe_empty", 64'(trace_valid_o), 64'd0);

        $display("[TB] flush");
        counter_i = 32'd60;
        apply_stimulus(1, 32'h300, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h304, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h308, 1, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h2, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h3, 0, 0);
        check_record("flush0", 32'h300, 32'h1, 32'd60, 32'd60, 32'd64, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_record("flush1", 32'h304, 32'h2, 32'd61, 32'd61, 32'd65, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_record("flush2", 32'h308, 32'h3, 32'd62, 32'd62, 32'd66, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("flush_empty", 64'(trace_valid_o), 64'd0);

        $display("[TB] backpressure and drops");
        counter_i = 32'd100;
        apply_stimulus(1, 32'h400, 1, 0, 0, 0, 0);
        for (int i = 1; i < 6; i++)
            apply_stimulus(1, 32'h400 + 32'(4 * i), 1, 1, 32'h100 + 32'(i - 1), 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h105, 0, 0);
        check_output("bp_drop", 64'(drop_cnt_o), 64'd2);
        check_record("bp_hold_a", 32'h400, 32'h100, 32'd100, 32'd100, 32'd101, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_record("bp_hold_b", 32'h400, 32'h100, 32'd100, 32'd100, 32'd101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_record($sformatf("bp_drain%0d", i), 32'h400 + 32'(4 * i), 32'h100 + 32'(i),
                         32'd100 + 32'(i), 32'd100 + 32'(i), 32'd101 + 32'(i), 1'b0);
            apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        end
        check_output("bp_empty", 64'(trace_valid_o), 64'd0);

        $display("[TB] grant overflow");
        counter_i = 32'd150;
        apply_stimulus(1, 32'h500, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h504, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h508, 1, 0, 0, 0, 0);
        check_output("ovf_err_before", 64'(proto_err_o), 64'd0);
        apply_stimulus(1, 32'h50C, 1, 0, 0, 0, 0);
        check_output("ovf_err_after", 64'(proto_err_o), 64'd1);
        apply_stimulus(0, 0, 0, 1, 32'h51, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h52, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h53, 0, 0);
        check_output("ovf_addr0", 64'(trace_addr_o), 64'h500);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("ovf_addr1", 64'(trace_addr_o), 64'h504);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("ovf_addr2", 64'(trace_addr_o), 64'h508);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("ovf_no_4th", 64'(trace_valid_o), 64'd0);
        check_output("ovf_err_sticky", 64'(proto_err_o), 64'd1);
        check_output("ovf_drop_kept", 64'(drop_cnt_o), 64'd2);

        $display("[TB] reset mid-transaction");
        counter_i = 32'd200;
        apply_stimulus(1, 32'h600, 1, 0, 0, 0, 0);
        apply_stimulus(1, 32'h604, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h61, 0, 0);
        apply_stimulus(1, 32'h608, 0, 0, 0, 0, 0);
        check_output("pre_rst_valid", 64'(trace_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", 64'(trace_valid_o), 64'd0);
        check_output("async_rst_addr",  64'(trace_addr_o),  64'd0);
        check_output("async_rst_drop",  64'(drop_cnt_o),    64'd0);
        check_output("async_rst_err",   64'(proto_err_o),   64'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 1, 32'h64, 0, 0);
        check_output("post_rst_orphan_err",   64'(proto_err_o),   64'd1);
        check_output("post_rst_orphan_valid", 64'(trace_valid_o), 64'd0);
        counter_i = 32'd300;
        apply_stimulus(1, 32'h700, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'h77, 0, 0);
        check_record("post_rst_fetch", 32'h700, 32'h77, 32'd300, 32'd300, 32'd301, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
